// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the IF stage: NOP encoding, IF/ID entry layout
// and the word-alignment helper used on redirect targets.
package instruction_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IFID_W           = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory channel: valid/ready request, fixed-order response.
// A request transfers on a clock edge where valid and ready are both high; valid
// never waits on ready. Responses carry no tag and return in request order.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Small synchronous FIFO used for the prefetch buffer and the request-address
// queue. Flush wins over push/pop; a push while full is legal only with a pop.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = IFID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty.
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instruction_fetch.sv
// RV32I IF stage: credit-limited in-order fetch, prefetch FIFO with bypass,
// and the IF/ID register with stall and redirect/flush handling.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                       sys_clk_i,
  input  logic                       rst_i,
  instruction_fetch_if.master        imem,
  input  logic                       stall_en_i,
  input  logic                       PCSrc_i,
  input  logic [31:0]                branch_target_i,
  output logic [31:0]                instruction_addr_o,
  output logic [31:0]                instruction_o,
  output logic                       instruction_valid_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW+1:0] in_use;

  logic          req_fire, rsp, rsp_drop, word_valid, bypass;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  ifid_t         fifo_din, fifo_dout;

  logic [31:0]   aq_head;
  logic          aq_full, aq_empty;
  logic [CW-1:0] aq_count;

  // Every credit covers a slot in the prefetch FIFO, so overflow cannot happen.
  assign in_use = {2'b00, outstanding} + {2'b00, fifo_count} + {2'b00, discard};
  assign imem.imem_req_valid_o = !rst_i && !PCSrc_i && (in_use < (CW+2)'(FIFO_DEPTH));
  assign imem.imem_req_addr_o  = pc_q;

  assign req_fire   = imem.imem_req_valid_o && imem.imem_req_ready_i;
  assign rsp        = imem.imem_rsp_valid_i;
  assign rsp_drop   = (discard != '0);
  assign word_valid = rsp && !rsp_drop && !PCSrc_i;
  assign bypass     = word_valid && fifo_empty && !stall_en_i;
  assign fifo_push  = word_valid && !bypass;
  assign fifo_pop   = !PCSrc_i && !stall_en_i && !fifo_empty;
  assign fifo_din   = '{addr: aq_head, inst: imem.imem_rsp_data_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_addr_q (
    .clk(sys_clk_i), .rst(rst_i),
    .push(req_fire), .pop(word_valid), .flush(PCSrc_i),
    .din(pc_q), .dout(aq_head),
    .full(aq_full), .empty(aq_empty), .count(aq_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(IFID_W)) u_prefetch (
    .clk(sys_clk_i), .rst(rst_i),
    .push(fifo_push), .pop(fifo_pop), .flush(PCSrc_i),
    .din(fifo_din), .dout(fifo_dout),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (PCSrc_i) begin
      // Everything still in memory becomes stale; a response at this edge is one of them.
      pc_q        <= word_align(branch_target_i);
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(rsp);
    end else begin
      if (req_fire) pc_q <= pc_q + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(word_valid);
      discard     <= discard - CW'(rsp && rsp_drop);
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      instruction_o       <= INST_NOP;
      instruction_addr_o  <= '0;
      instruction_valid_o <= 1'b0;
    end else if (PCSrc_i) begin
      instruction_o       <= INST_NOP;
      instruction_valid_o <= 1'b0;
    end else if (!stall_en_i) begin
      if (!fifo_empty) begin
        instruction_o       <= fifo_dout.inst;
        instruction_addr_o  <= fifo_dout.addr;
        instruction_valid_o <= 1'b1;
      end else if (bypass) begin
        instruction_o       <= fifo_din.inst;
        instruction_addr_o  <= fifo_din.addr;
        instruction_valid_o <= 1'b1;
      end else begin
        instruction_o       <= INST_NOP;
        instruction_valid_o <= 1'b0;
      end
    end
  end

  queue_chk: assert property (@(posedge sys_clk_i) disable iff (rst_i)
    (aq_count == outstanding) && !(word_valid && aq_empty) &&
    !(req_fire && aq_full) && !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage RV32I pipeline; producer side of the IF→ID interface that `instruction_decode` consumes.
- Generates the PC and issues in-order requests to instruction memory through a valid/ready request channel and a fixed-order response channel.
- Buffers returned words in a small prefetch FIFO and drives the IF/ID register: instruction, address and valid.
- Honours `stall_en_i` (hold) and `PCSrc_i` (redirect/flush) from the hazard detection unit.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch entries; also the maximum in-flight plus buffered requests. Must be a power of 2, ≥2.

Ports:
- sys_clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request this cycle.
- imem_req_addr_o  out  32  word-aligned fetch address (= pc_q).
- imem_rsp_valid_i  in  1  response valid; in order; ≥1 cycle after acceptance.
- imem_rsp_data_i  in  32  instruction word.
- stall_en_i  in  1  hold the IF/ID register and PC-visible state.
- PCSrc_i  in  1  taken branch/jump; redirect and flush.
- branch_target_i  in  32  redirect address; bits[1:0] forced to 0.
- instruction_addr_o  out  32  IF/ID: PC of the instruction.
- instruction_o  out  32  IF/ID: instruction word.
- instruction_valid_o  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset: clock and reset as decided — one clock, `sys_clk_i`; reset `rst_i` is asynchronous and active-high.
- Reset values:
  - pc_q = RESET_PC; outstanding = 0; discard = 0; FIFO empty.
  - instruction_o = `INST_NOP (32'h0000_0013); instruction_addr_o = 0; instruction_valid_o = 0.
  - imem_req_valid_o = 0.
- Credit rule: imem_req_valid_o = !PCSrc_i && (outstanding + fifo_count + discard < FIFO_DEPTH). This never depends on imem_req_ready_i.
- Request accepted (valid && ready): pc_q += 4 (mod 2^32 wrap), outstanding++. A FIFO_DEPTH-deep address queue records the request PC.
- Response:
  - If discard > 0: drop the word, discard--.
  - Else: pair the word with the head of the address queue and outstanding--.
  - The word then bypasses into the IF/ID register if the FIFO is empty and there is no stall; otherwise it is pushed into the FIFO.
- IF/ID update on each edge, in priority order:
  - PCSrc_i: load NOP, valid = 0, address held.
  - Else stall_en_i: hold all three outputs.
  - Else FIFO non-empty: pop the head into the outputs, valid = 1.
  - Else a bypass response is present: load it, valid = 1.
  - Else: load NOP, valid = 0.
- Redirect (PCSrc_i = 1 at edge N):
  - pc_q = {branch_target_i[31:2], 2'b00}.
  - FIFO and address queue cleared.
  - discard = outstanding + (response arriving at edge N is excluded, i.e. dropped); outstanding = 0.
  - No request is issued during the PCSrc_i cycle.
- Simultaneous events:
  - PCSrc_i overrides stall_en_i.
  - A response arriving in the same cycle as a redirect is dropped.
  - Push and pop in the same cycle are allowed when the FIFO is full.
- Latency: with a 1-cycle memory and ready held high, the target request is issued in cycle N+1, its response arrives in cycle N+2, and instruction_valid_o = 1 with instruction_addr_o = target after edge N+2.
- Stall: requests continue until credits are exhausted, then stop. No word is lost or duplicated.
- FIFO overflow cannot occur by construction. Any push while full is an assertion failure in simulation.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are the memory's responsibility; it must also reset.

Decomposition:
- Shared defines file (already included by the pipeline): `INST_NOP, RESET_PC default, and the IF/ID bus width.
- Sub-module fetch_fifo: synchronous FIFO, parameters DEPTH and WIDTH = 64 ({addr, inst}).
  - Ports: push, pop, flush, full, empty, count.
  - Reused for the request-address queue with WIDTH = 32.

Test Plan:
- Reset release, memory ready = 1, 1-cycle latency returning addr+0x100:
  - Requests at 0x0, 0x4, 0x8.
  - IF/ID shows (0x0, 0x100), (0x4, 0x104), … with valid continuous from the 3rd cycle.
- stall_en_i held for 5 cycles mid-stream:
  - Outputs frozen.
  - imem_req_valid_o drops after 2 outstanding/buffered.
  - After release, the sequence resumes with no gap in addresses and no duplicates.
- PCSrc_i with target 0x0000_0203 while 2 requests are in flight:
  - Next output is NOP, valid = 0.
  - Both stale responses are dropped.
  - Next request address is 0x200; the first valid instruction has addr 0x200.
- PCSrc_i and stall_en_i asserted together: flush wins, IF/ID = NOP, valid = 0.
- imem_req_ready_i low for 4 cycles, then a 3-cycle response latency:
  - Address is stable while waiting.
  - Order is preserved; no more than FIFO_DEPTH credits are used.
- rst_i asserted asynchronously mid-stream:
  - Outputs become NOP/0/0 without waiting for a clock edge.
  - Fetch restarts at RESET_PC after release.
